regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A = ALU result, B = load data.
- Uses a valid/ready handshake on each requester and round-robin arbitration on contention.
- Registers the winning request onto the regfile write port one cycle after acceptance.
- Drops writes to register 0 ($zero), consistent with MIPS semantics, and counts contention cycles for performance debug.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- freeze  input  1  pipeline stall; blocks all grants while high.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  grant to A; combinational.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  grant to B; combinational.
- we  output  1  regfile write enable; registered.
- waddr  output  ADDR_W  regfile write address; registered.
- wdata  output  DATA_W  regfile write data; registered.
- conflict_cnt  output  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (async, active-high): we=0, waddr=0, wdata=0, conflict_cnt=0, priority state = PRIO_A. a_ready=b_ready=0 while reset is high.
- Priority FSM (1 bit):
  - States PRIO_A and PRIO_B.
  - Transitions happen only on a contended grant: both valid, freeze=0.
  - PRIO_A with contention -> grant A, next state PRIO_B.
  - PRIO_B with contention -> grant B, next state PRIO_A.
  - Uncontended grants and idle cycles leave the state unchanged.
- Grant logic, combinational:
  - freeze=1 -> a_ready=b_ready=0.
  - Otherwise, only A valid -> a_ready=1; only B valid -> b_ready=1; both valid -> grant the side that has priority.
  - a_ready and b_ready are never both 1.
  - ready never asserts without the matching valid.
- Transfer: a transfer occurs on a cycle where valid&ready is true for that requester. A requester with valid=1 and ready=0 holds addr/data stable and keeps valid high.
- Latency: one cycle. In the cycle after a transfer with addr!=0: we=1, waddr and wdata equal the transferred values.
- Address 0:
  - The transfer is accepted: ready=1 and the handshake completes.
  - The following cycle has we=0; waddr and wdata hold their previous values.
- Idle:
  - A cycle with no transfer gives we=0 in the next cycle.
  - waddr and wdata hold their values; they update only when we is asserted.
- Same destination from both requesters in one cycle:
  - The granted request writes first.
  - The loser writes in a later cycle, so the loser's data is final.
  - No merging or forwarding is done.
- conflict_cnt:
  - Increments by 1 on each cycle with a_valid=b_valid=1 and freeze=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- freeze:
  - Priority state and conflict_cnt are unchanged while freeze is high.
  - A write already registered still presents its we pulse in the cycle after it was accepted.
- Reset asserted mid-operation:
  - we drops immediately, asynchronously.
  - A transfer accepted in the previous cycle is lost.
  - Requesters must re-present after reset deasserts.
- Throughput: at most one write per cycle. With sustained contention, A and B alternate one grant each.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the ZERO_REG constant (0), and the PRIO_A/PRIO_B state encoding.
- One natural sub-module, rr_arb2: a 2-input round-robin grant unit with a 1-bit priority state and freeze input. The top level adds the payload mux, output registers, the $zero filter and the counter.

Test Plan:
- Reset then single A write: a_valid=1, a_addr=5, a_data=32'hDEADBEEF, freeze=0 -> a_ready=1 same cycle; next cycle we=1, waddr=5, wdata=32'hDEADBEEF; cycle after, we=0.
- Contention: A(addr 3, data 1) and B(addr 4, data 2) held valid from reset -> grants A,B on consecutive cycles; we pulses write 3/1 then 4/2; conflict_cnt=1.
- Sustained contention of 4 cycles, both requesters re-presenting new data each grant -> grant order A,B,A,B; conflict_cnt=4; final state PRIO_A.
- Write to $zero: b_valid=1, b_addr=0, b_data=32'hFFFFFFFF -> b_ready=1; next cycle we=0; waddr and wdata unchanged.
- Freeze then release: both valid, freeze=1 for 3 cycles -> ready=0 and conflict_cnt unchanged throughout; on freeze=0, the side holding priority is granted first.
- Reset mid-transfer: A accepted (addr 7), reset asserted before the next clock edge -> we=0 immediately; after deassert, state is PRIO_A and conflict_cnt=0. Also: force 300 contention cycles -> conflict_cnt=255 and holds.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and the round-robin priority encoding for the
// register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 8;

    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-input round-robin grant unit; priority flips only on a contended grant.
module rr_arb2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    prio_t state;
    prio_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PRIO_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (req_a && req_b && !freeze) begin
            state_next = (state == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    // Grants are suppressed during reset as well as freeze so nothing handshakes mid-reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset && !freeze) begin
            if (req_a && (!req_b || state == PRIO_A)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B)
// writeback paths, drops $zero writes and counts contention cycles.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              write_ok;
    logic              contended;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .freeze (freeze),
        .req_a  (a_valid),
        .req_b  (b_valid),
        .gnt_a  (a_ready),
        .gnt_b  (b_ready)
    );

    always_comb begin
        xfer     = (a_valid && a_ready) || (b_valid && b_ready);
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
        write_ok = xfer && (sel_addr != ZERO_A);
        contended = a_valid && b_valid && !freeze;
    end

    // $zero transfers still handshake but never reach the port; address/data hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= write_ok;
            if (write_ok) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (contended && conflict_cnt != CNT_MAX) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scoreboard of expected
// write-port results.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  conflict_cnt;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fz,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        freeze  = fz;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
        end else begin
            e = sb.pop_front();
            check({tag, "_we"}, 64'(we), 64'(e.we));
            check({tag, "_waddr"}, 64'(waddr), 64'(e.addr));
            check({tag, "_wdata"}, 64'(wdata), 64'(e.data));
        end
    endtask

    // Checks the grant for the current inputs, queues the expected write-port result, clocks once.
    task automatic cycle(input string tag, input logic exp_a, input logic exp_b);
        exp_t e;
        #1;
        check({tag, "_a_ready"}, 64'(a_ready), 64'(exp_a));
        check({tag, "_b_ready"}, 64'(b_ready), 64'(exp_b));
        e.we   = 1'b0;
        e.addr = last_addr;
        e.data = last_data;
        if (exp_a && a_addr != 5'd0) begin
            e.we = 1'b1; e.addr = a_addr; e.data = a_data;
        end else if (exp_b && b_addr != 5'd0) begin
            e.we = 1'b1; e.addr = b_addr; e.data = b_data;
        end
        last_addr = e.addr;
        last_data = e.data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        cycle(tag, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 1, 5'd9, 32'h1234, 0, 5'd0, 32'd0);
        #12;
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        cycle("single_a", 1, 0);
        idle("single_a_idle");

        applyStimulus(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2);
        cycle("cont_a", 1, 0);
        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd4, 32'd2);
        cycle("cont_b", 0, 1);
        idle("cont_idle");
        check("cont_cnt", 64'(conflict_cnt), 64'd1);

        reset = 1'b1;
        #2;
        reset = 1'b0;
        last_addr = '0;
        last_data = '0;
        check("rst2_cnt", 64'(conflict_cnt), 64'd0);
        check("rst2_waddr", 64'(waddr), 64'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 5'd8, 32'hA000 + 32'(i), 1, 5'd9, 32'hB000 + 32'(i));
            cycle($sformatf("sust%0d", i), (i % 2) == 0, (i % 2) == 1);
        end
        check("sust_cnt", 64'(conflict_cnt), 64'd4);
        applyStimulus(0, 1, 5'd8, 32'hA004, 1, 5'd9, 32'hB004);
        cycle("sust_prio_a", 1, 0);
        check("sust_cnt5", 64'(conflict_cnt), 64'd5);
        idle("sust_idle");

        applyStimulus(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF);
        cycle("zero_b", 0, 1);
        idle("zero_idle");

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 5'd10, 32'hAAAA, 1, 5'd11, 32'hBBBB);
            cycle($sformatf("frz%0d", i), 0, 0);
            check($sformatf("frz%0d_cnt", i), 64'(conflict_cnt), 64'd5);
        end
        applyStimulus(0, 1, 5'd10, 32'hAAAA, 1, 5'd11, 32'hBBBB);
        cycle("frz_rel_b", 0, 1);
        applyStimulus(0, 1, 5'd10, 32'hAAAA, 0, 5'd0, 32'd0);
        cycle("frz_rel_a", 1, 0);
        idle("frz_idle");
        check("frz_cnt", 64'(conflict_cnt), 64'd6);

        applyStimulus(0, 1, 5'd7, 32'h77, 1, 5'd12, 32'hCC);
        #1;
        check("mid_a_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        check("mid_we_pre", 64'(we), 64'd1);
        check("mid_waddr_pre", 64'(waddr), 64'd7);
        reset = 1'b1;
        applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        check("mid_we_async", 64'(we), 64'd0);
        check("mid_waddr_async", 64'(waddr), 64'd0);
        check("mid_cnt_async", 64'(conflict_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_addr = '0;
        last_data = '0;
        applyStimulus(0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        cycle("post_rst_prio", 1, 0);
        idle("post_rst_idle");
        check("post_rst_cnt", 64'(conflict_cnt), 64'd1);

        applyStimulus(0, 1, 5'd13, 32'h13, 1, 5'd14, 32'h14);
        repeat (300) @(posedge clk);
        #1;
        check("sat_cnt", 64'(conflict_cnt), 64'd255);
        repeat (10) @(posedge clk);
        #1;
        check("sat_hold", 64'(conflict_cnt), 64'd255);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
